// File: rtl/conv_tap_engine.sv
// MAC stage between the convolution register file and the result sink: reads
// DEPTH stored samples, weights each by a local coefficient and returns the sum.
module conv_tap_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int ADDR  = 3,
  parameter int ACC_W = 2*WIDTH+3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             coef_we,
  input  logic [ADDR-1:0]  coef_idx,
  input  logic [WIDTH-1:0] coef_data,
  input  logic             reg_wrEn,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_valid,
  output logic             RdEn,
  output logic [ADDR-1:0]  RdAddr,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH-1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] coef [DEPTH];
  logic [ADDR-1:0]  ptr_p0;
  logic             issue_p0;
  logic             vld_p1;
  logic [ADDR-1:0]  idx_p1;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // Unsigned product, zero-extended; the width budget makes overflow impossible.
  function automatic logic [ACC_W-1:0] mac_term(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return ACC_W'(p);
  endfunction

  assign acc_sum      = acc + mac_term(RdData, coef[idx_p1]);
  assign busy         = (state != IDLE);
  assign result_valid = (state == OUT);

  always_comb begin
    state_nxt = state;
    issue_p0  = 1'b0;
    RdEn      = 1'b0;
    RdAddr    = '0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        RdEn   = 1'b1;
        RdAddr = ptr_p0;
        if (!reg_wrEn) begin
          issue_p0 = 1'b1;
          if (ptr_p0 == LAST) state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = OUT;
      OUT:   if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr_p0 <= '0;
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      acc    <= '0;
      result <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) coef[i] <= '0;
    end else begin
      state <= state_nxt;
      if (coef_we && !busy && coef_idx <= LAST) coef[coef_idx] <= coef_data;

      // Stage p0 -> p1: an issued read becomes a pending capture of its address.
      vld_p1 <= issue_p0;
      if (issue_p0) begin
        idx_p1 <= ptr_p0;
        ptr_p0 <= ptr_p0 + 1'b1;
      end

      // Stage p1: read data arrives; accumulate it.
      if (state == IDLE && start) begin
        acc    <= '0;
        ptr_p0 <= '0;
      end else if (vld_p1) begin
        acc <= acc_sum;
        if (!RdData_valid) err <= 1'b1;
      end
      if (state == DRAIN) result <= acc_sum;
    end
  end

endmodule

// File: tb/tb_conv_tap_engine.sv
// Randomized scoreboard bench for conv_tap_engine with a register-file model.
module tb_conv_tap_engine;

  logic        clk = 1'b0;
  logic        rst, start, coef_we, reg_wrEn, RdData_valid, result_ready;
  logic [2:0]  coef_idx;
  logic [7:0]  coef_data, RdData;
  logic        RdEn, busy, result_valid, err;
  logic [2:0]  RdAddr;
  logic [18:0] result;

  conv_tap_engine dut (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_data(coef_data), .reg_wrEn(reg_wrEn), .RdData(RdData),
    .RdData_valid(RdData_valid), .RdEn(RdEn), .RdAddr(RdAddr), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int res; bit err; int due;} exp_t;
  exp_t exp_q[$];

  logic [7:0] mem    [5];
  logic [7:0] coef_m [5];
  int  cyc = 0;
  int  kill_addr = -1;
  bit  err_sticky = 0;
  int  total = 0;
  int  bad = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency; a write in the same cycle wins.
  always @(posedge clk) begin
    if (RdEn && !reg_wrEn) begin
      RdData       <= mem[RdAddr];
      RdData_valid <= (int'(RdAddr) != kill_addr);
    end
  end

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (result_valid && !prev_v) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency", cyc, exp_q[0].due);
      end
      if (result_valid && result_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("err", err, e.err);
      end
      prev_v <= result_valid;
    end
  end

  task automatic wcoef(input int idx, input logic [7:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_idx = 3'(idx); coef_data = d;
    if (idx < 5) coef_m[idx] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic rand_all(input bit do_coef);
    for (int i = 0; i < 5; i++) begin
      mem[i] = 8'($urandom);
      if (do_coef) wcoef(i, 8'($urandom));
    end
  endtask

  task automatic run(input int coll, input int kill, input int lock_at, input int hold);
    int t0, exp_sum, nxt, off, w;
    exp_sum = 0;
    for (int i = 0; i < 5; i++) exp_sum += int'(mem[i]) * int'(coef_m[i]);
    if (kill >= 0) err_sticky = 1;
    @(negedge clk);
    t0 = cyc;
    exp_q.push_back('{exp_sum, err_sticky, t0 + 7 + ((coll > 0) ? 1 : 0)});
    start = 1'b1;
    kill_addr = kill;
    nxt = 0;
    for (off = 1; nxt < 5; off++) begin
      @(negedge clk);
      start     = 1'b0;
      reg_wrEn  = (off == coll);
      coef_we   = (off == lock_at);
      coef_idx  = 3'd0;
      coef_data = coef_m[0] + 8'd1;
      check("rd_en", RdEn, 1);
      check("rd_addr", RdAddr, nxt);
      if (off == 1) check("busy_start", busy, 1);
      if (off != coll) nxt++;
    end
    @(negedge clk);
    reg_wrEn = 1'b0; coef_we = 1'b0;
    check("rd_en_drain", RdEn, 0);
    w = 0;
    while (!result_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("valid_seen", result_valid, 1);
    for (int h = 0; h < hold; h++) begin
      check("bp_valid", result_valid, 1);
      check("bp_result", result, exp_sum);
      start = (h % 3 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    kill_addr = -1;
    check("busy_after", busy, 0);
    check("valid_after", result_valid, 0);
    check("result_kept", result, exp_sum);
  endtask

  initial begin
    int coll;
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int coll;
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    reg_wrEn = 1'b0; result_ready = 1'b0; RdData = '0; RdData_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin mem[i] = '0; coef_m[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_rden", RdEn, 0);
    check("rst_rdaddr", RdAddr, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin wcoef(i, 8'(i + 1)); mem[i] = 8'(10 * (i + 1)); end
    run(-1, -1, -1, 0);

    for (int i = 0; i < 5; i++) begin wcoef(i, 8'd255); mem[i] = 8'd255; end
    run(-1, -1, -1, 0);

    rand_all(1);
    run(-1, -1, -1, 10);
    rand_all(0);
    run(-1, -1, -1, 0);

    rand_all(1);
    run(3, -1, -1, 0);

    for (int k = 0; k < 6; k++) begin
      rand_all(1);
      coll = int'($urandom_range(0, 5));
      run((coll == 0) ? -1 : coll, -1, -1, int'($urandom_range(0, 3)));
    end

    wcoef(5, 8'hAA); wcoef(6, 8'h55); wcoef(7, 8'hFF);
    rand_all(0);
    run(-1, -1, 2, 0);

    rand_all(1);
    run(-1, 2, -1, 0);
    rand_all(0);
    run(-1, -1, -1, 2);
    check("err_sticky", err, 1);

    rand_all(0);
    @(negedge clk);
    start = 1'b1;
    repeat (4) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) coef_m[i] = '0;
    err_sticky = 0;
    check("abort_rden", RdEn, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_valid", result_valid, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    check("abort_rden_next", RdEn, 0);
    run(-1, -1, -1, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
